// File: rtl/braid_mix_pipe.sv
`timescale 1ns/1ps
// ============================================================================
// braid_mix_pipe
// ----------------------------------------------------------------------------
// Purpose:
//   This is a fixed-latency pipeline of STAGES braid-mixing stages for
//   CHANNELS fluid concentration channels. Each stage holds a valid bit, a
//   mode bit and one data word.
//
//   In braid mode (mode 0), stage s replaces every channel c with the average
//   of itself and a partner channel:
//       p(c,s) = (c + 1 + (s mod (CHANNELS-1))) mod CHANNELS
//   The partner offset rotates from stage to stage, so after enough stages
//   every channel has been blended with every other channel.
//
//   In pass-through mode (mode 1), the frame crosses every stage unchanged.
//   The mode bit travels with its own frame.
//
//   Flow control is a global stall. The whole pipe shifts when the last stage
//   is empty or when downstream is ready. Bubbles are never compressed, so a
//   frame always takes exactly STAGES cycles to cross an unstalled pipe.
//
// Configuration macro:
//   BRAID_MIX_ROUND_EN
//     defined   : mix(a,b) = (a+b+1)>>1   (round half up)
//     undefined : mix(a,b) = (a+b)>>1     (truncate, default build)
//
// Parameters:
//   CHANNELS  number of channels, 2..16
//   STAGES    number of mixing stages, 1..64
//   WIDTH     unsigned concentration bits per channel
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   input frame present
//   in_ready   input frame accepted when in_valid && in_ready
//   in_data    input concentrations; channel c is at [c*WIDTH +: WIDTH]
//   in_mode    0 = braid mix, 1 = pass-through
//   out_valid  output frame present (driven from the last stage)
//   out_ready  downstream accepts the output frame
//   out_data   output concentrations, packed the same way as in_data
//   out_mode   mode of the frame on out_data
//   occupancy  number of valid frames held in the pipeline
// ============================================================================
module braid_mix_pipe #(
   parameter int CHANNELS = 3,
   parameter int STAGES   = 32,
   parameter int WIDTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*WIDTH-1:0]     in_data,
   input  logic                          in_mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS*WIDTH-1:0]     out_data,
   output logic                          out_mode,
   output logic [$clog2(STAGES+1)-1:0]   occupancy
);

   localparam int DW    = CHANNELS * WIDTH;
   localparam int OCC_W = $clog2(STAGES + 1);

`ifdef BRAID_MIX_ROUND_EN
   localparam logic ROUND_BIT = 1'b1;
`else
   localparam logic ROUND_BIT = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Stage state and next-state values
   // -------------------------------------------------------------------------
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] mode_q;
   logic [DW-1:0]     data_q [STAGES];

   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] mode_d;
   logic [DW-1:0]     data_d [STAGES];

   // Data as it arrives at each stage, before that stage mixes it
   logic [DW-1:0]     stage_x [STAGES];
   // The same data after the stage has mixed it in braid mode
   logic [DW-1:0]     stage_mix [STAGES];

   logic [OCC_W-1:0]  occ_q;
   logic [OCC_W-1:0]  occ_d;

   logic              advance;
   logic              accept;
   logic              emit;

   // -------------------------------------------------------------------------
   // Handshake
   // -------------------------------------------------------------------------
   // The pipe may shift whenever the last stage has room or is being drained.
   // in_ready depends only on these two terms, so no path runs from in_valid
   // to in_ready.
   assign advance  = !valid_q[STAGES-1] || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;
   assign emit     = valid_q[STAGES-1] && out_ready;

   // -------------------------------------------------------------------------
   // Per-stage datapath
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Stage 0 is fed from the input port; every later stage is fed from
      // the stage in front of it.
      if (gi == 0) begin : g_first
         assign stage_x[gi] = in_data;
         assign valid_d[gi] = in_valid;
         assign mode_d[gi]  = in_mode;
      end else begin : g_rest
         assign stage_x[gi] = data_q[gi-1];
         assign valid_d[gi] = valid_q[gi-1];
         assign mode_d[gi]  = mode_q[gi-1];
      end

      // The partner index is fixed at elaboration time, so each channel
      // reduces to a single adder with no multiplexing.
      for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chan
         localparam int PARTNER = (gc + 1 + (gi % (CHANNELS - 1))) % CHANNELS;

         logic [WIDTH-1:0] a_val;
         logic [WIDTH-1:0] b_val;
         logic [WIDTH:0]   sum;

         assign a_val = stage_x[gi][gc*WIDTH +: WIDTH];
         assign b_val = stage_x[gi][PARTNER*WIDTH +: WIDTH];

         // The extra bit keeps the carry, so the average can never wrap.
         assign sum = {1'b0, a_val} + {1'b0, b_val} + {{WIDTH{1'b0}}, ROUND_BIT};

         assign stage_mix[gi][gc*WIDTH +: WIDTH] = WIDTH'(sum >> 1);
      end

      // Data and mode are loaded even when the incoming valid bit is 0;
      // only the valid bit says whether the stage contents mean anything.
      assign data_d[gi] = mode_d[gi] ? stage_x[gi] : stage_mix[gi];
   end

   // -------------------------------------------------------------------------
   // Occupancy next state
   // -------------------------------------------------------------------------
   always_comb begin
      occ_d = occ_q;
      if (accept && !emit) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!accept && emit) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // Reset clears every stage, including data and mode, so a frame that was
   // in flight can never reappear after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         mode_q  <= '0;
         occ_q   <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         // A stall freezes the whole pipe, bubbles included.
         if (advance) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            for (int s = 0; s < STAGES; s++) begin
               data_q[s] <= data_d[s];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs come straight from the last stage registers
   // -------------------------------------------------------------------------
   assign out_valid = valid_q[STAGES-1];
   assign out_mode  = mode_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign occupancy = occ_q;

endmodule
